// File: rtl/ram_arbiter.sv
// Three-requester arbiter in front of a single-port synchronous RAM.
// Round-robin grant, one four-cycle access (IDLE/ACCESS/RESP/DONE) per request, all outputs registered.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic              fetch_read,
  output logic              fetch_read_ready,
  input  logic [ADDR_W-1:0] fetch_read_address,
  output logic [DATA_W-1:0] fetch_read_data_out,
  input  logic              load_read,
  output logic              load_read_ready,
  input  logic [ADDR_W-1:0] load_read_address,
  output logic [DATA_W-1:0] load_read_data_out,
  input  logic              store_save,
  output logic              store_save_ready,
  input  logic [ADDR_W-1:0] store_save_address,
  input  logic [DATA_W-1:0] store_save_data_in,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  localparam logic [1:0] PORT_FETCH = 2'd0;
  localparam logic [1:0] PORT_LOAD  = 2'd1;
  localparam logic [1:0] PORT_STORE = 2'd2;
  localparam logic [1:0] NO_GRANT   = 2'd3;

  state_t            state, state_nxt;
  logic [1:0]        last_granted, last_granted_nxt;
  logic [1:0]        grant_nxt;
  logic              busy_nxt;
  logic              we_nxt;
  logic              fetch_ready_nxt, load_ready_nxt, store_ready_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] fetch_data_nxt, load_data_nxt;
  logic [2:0]        req;
  logic [2:0]        pick;

  assign req = {store_save, load_read, fetch_read};

  // Returns {hit, port}; search starts one past the last granted port and wraps 2 -> 0.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] cand;
    rr_pick = 3'b000;
    cand = (last == PORT_STORE) ? PORT_FETCH : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!rr_pick[2] && r[cand]) rr_pick = {1'b1, cand};
      cand = (cand == PORT_STORE) ? PORT_FETCH : cand + 2'd1;
    end
  endfunction

  always_comb begin
    state_nxt        = state;
    last_granted_nxt = last_granted;
    grant_nxt        = grant;
    busy_nxt         = busy;
    we_nxt           = ram_write_enable;
    addr_nxt         = ram_address;
    wdata_nxt        = ram_data_in;
    fetch_ready_nxt  = fetch_read_ready;
    load_ready_nxt   = load_read_ready;
    store_ready_nxt  = store_save_ready;
    fetch_data_nxt   = fetch_read_data_out;
    load_data_nxt    = load_read_data_out;
    pick             = rr_pick(req, last_granted);

    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nxt        = ACCESS;
          busy_nxt         = 1'b1;
          grant_nxt        = pick[1:0];
          last_granted_nxt = pick[1:0];
          case (pick[1:0])
            PORT_LOAD: addr_nxt = load_read_address;
            PORT_STORE: begin
              addr_nxt  = store_save_address;
              wdata_nxt = store_save_data_in;
              we_nxt    = 1'b1;
            end
            default: addr_nxt = fetch_read_address;
          endcase
        end
      end
      ACCESS: begin
        // RAM commits the write / launches the read on this edge
        we_nxt    = 1'b0;
        state_nxt = RESP;
      end
      RESP: begin
        case (grant)
          PORT_FETCH: begin
            fetch_ready_nxt = 1'b1;
            fetch_data_nxt  = ram_data_out;
          end
          PORT_LOAD: begin
            load_ready_nxt = 1'b1;
            load_data_nxt  = ram_data_out;
          end
          default: store_ready_nxt = 1'b1;
        endcase
        state_nxt = DONE;
      end
      DONE: begin
        fetch_ready_nxt = 1'b0;
        load_ready_nxt  = 1'b0;
        store_ready_nxt = 1'b0;
        grant_nxt       = NO_GRANT;
        busy_nxt        = 1'b0;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      last_granted        <= PORT_STORE;
      grant               <= NO_GRANT;
      busy                <= 1'b0;
      ram_write_enable    <= 1'b0;
      ram_address         <= '0;
      ram_data_in         <= '0;
      fetch_read_ready    <= 1'b0;
      load_read_ready     <= 1'b0;
      store_save_ready    <= 1'b0;
      fetch_read_data_out <= '0;
      load_read_data_out  <= '0;
    end else begin
      state               <= state_nxt;
      last_granted        <= last_granted_nxt;
      grant               <= grant_nxt;
      busy                <= busy_nxt;
      ram_write_enable    <= we_nxt;
      ram_address         <= addr_nxt;
      ram_data_in         <= wdata_nxt;
      fetch_read_ready    <= fetch_ready_nxt;
      load_read_ready     <= load_ready_nxt;
      store_save_ready    <= store_ready_nxt;
      fetch_read_data_out <= fetch_data_nxt;
      load_read_data_out  <= load_data_nxt;
    end
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, width of every address bus.
REQ-002 Parameter DATA_W, default 8, width of every data bus.
REQ-003 Port ram_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Ports fetch_read in 1 / fetch_read_ready out 1 / fetch_read_address in ADDR_W / fetch_read_data_out out DATA_W: instruction-fetch read requester (port 0).
REQ-006 Ports load_read in 1 / load_read_ready out 1 / load_read_address in ADDR_W / load_read_data_out out DATA_W: register-load read requester (port 1).
REQ-007 Ports store_save in 1 / store_save_ready out 1 / store_save_address in ADDR_W / store_save_data_in in DATA_W: register-store write requester (port 2).
REQ-008 Ports ram_write_enable out 1 / ram_address out ADDR_W / ram_data_in out DATA_W / ram_data_out in DATA_W: single-port synchronous RAM; RAM samples on rising edge, read data registered, 1-cycle latency.
REQ-009 Port busy  out 1  high whenever state is not IDLE.
REQ-010 Port grant  out 2  index of port being served (0 fetch, 1 load, 2 store); 3 when IDLE.

Function
REQ-011 FSM states SHALL be IDLE, ACCESS, RESP, DONE; all outputs registered.
REQ-012 IDLE: if any request high at the edge, select one per REQ-015, latch its address (and write data for store) into ram_address/ram_data_in, set ram_write_enable=1 only for store, set grant, go ACCESS; else stay IDLE.
REQ-013 ACCESS: RAM performs the access at this edge; arbiter drops ram_write_enable to 0, goes RESP.
REQ-014 RESP: for a read, capture ram_data_out into the granted port's *_data_out; assert granted port's ready; go DONE.
REQ-015 Arbitration SHALL be round-robin: search order starts at (last_granted+1) mod 3 over ports 0,1,2; last_granted updated on every grant.
REQ-016 DONE: ready held high exactly this one cycle, no arbitration; next edge clears ready, grant=3, goes IDLE.
REQ-017 Latency: request sampled at IDLE edge E -> ready high from edge E+2 to E+3; one access per 4 cycles max.
REQ-018 Requesters SHALL keep request, address and data stable until ready, and deassert request at the edge ending DONE; a request still high in IDLE is a new request.
REQ-019 Address/data sampled only at grant; changes afterwards do not affect the in-flight access.
REQ-020 *_data_out SHALL hold last captured value until the next read for that port completes; a store never alters any *_data_out.
REQ-021 Simultaneous requests: only one granted; others remain pending and are served in later rounds in round-robin order; no port waits more than two other grants.
REQ-022 Requests deasserted before grant are dropped with no RAM access and no ready.
REQ-023 ram_write_enable SHALL be high for exactly one cycle (the ACCESS cycle) per store and never during reads.

Reset
REQ-024 rst high SHALL immediately force state IDLE, all ready=0, ram_write_enable=0, ram_address=0, ram_data_in=0, *_data_out=0, busy=0, grant=3, last_granted=2 (first priority fetch).
REQ-025 Reset mid-operation abandons the access: no ready pulse; a store reset before its ACCESS edge SHALL not write RAM.
REQ-026 First request after rst falls is evaluated at the first rising edge with rst low.

Verification
REQ-027 Single fetch: RAM[0x0000]=0x01, fetch_read@0x0000 -> fetch_read_ready pulse 1 cycle at E+2, fetch_read_data_out=0x01, ram_write_enable never high.
REQ-028 Store then load: store 0xA5@0x0040, then load_read@0x0040 -> store_save_ready once, ram_write_enable one cycle, load_read_data_out=0xA5.
REQ-029 All three request same edge from reset -> grant order 0,1,2, each ready exactly once, 12 cycles total.
REQ-030 Fetch and store held continuously (re-requesting after ready) -> grants alternate 0,2,0,2; load never starves when added (served within two grants).
REQ-031 rst asserted during ACCESS of store 0x77@0x0010 (rst before edge) -> RAM[0x0010] unchanged, no ready, all outputs at reset values same cycle.
REQ-032 Address changed after grant: load_read@0x0005 then bus switched to 0x0006 in ACCESS -> data from 0x0005 returned.
